// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture block: active-low gfedcba
// digit patterns and the pattern-to-BCD decode used by every channel.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] DIG_NONE  = 4'hF;

    typedef struct packed {
        logic [3:0] bcd;
        logic       blank;
        logic       err;
    } seg7_dec_t;

    localparam seg7_dec_t DEC_RESET = '{bcd: DIG_NONE, blank: 1'b1, err: 1'b0};

    // Anything that is neither a digit nor fully dark is reported as an error.
    function automatic seg7_dec_t seg7_to_bcd(input logic [6:0] seg);
        seg7_dec_t res;
        res = '{bcd: DIG_NONE, blank: 1'b0, err: 1'b1};
        case (seg)
            SEG_0:     res = '{bcd: 4'd0, blank: 1'b0, err: 1'b0};
            SEG_1:     res = '{bcd: 4'd1, blank: 1'b0, err: 1'b0};
            SEG_2:     res = '{bcd: 4'd2, blank: 1'b0, err: 1'b0};
            SEG_3:     res = '{bcd: 4'd3, blank: 1'b0, err: 1'b0};
            SEG_4:     res = '{bcd: 4'd4, blank: 1'b0, err: 1'b0};
            SEG_5:     res = '{bcd: 4'd5, blank: 1'b0, err: 1'b0};
            SEG_6:     res = '{bcd: 4'd6, blank: 1'b0, err: 1'b0};
            SEG_7:     res = '{bcd: 4'd7, blank: 1'b0, err: 1'b0};
            SEG_8:     res = '{bcd: 4'd8, blank: 1'b0, err: 1'b0};
            SEG_9:     res = '{bcd: 4'd9, blank: 1'b0, err: 1'b0};
            SEG_BLANK: res = '{bcd: DIG_NONE, blank: 1'b1, err: 1'b0};
            default:   res = '{bcd: DIG_NONE, blank: 1'b0, err: 1'b1};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_capture_if.sv
// Bundle of segment inputs and decoded outputs between the capture block and
// whatever drives or observes it.
interface seg7_capture_if #(
    parameter int NDIG = 6
);
    logic [7*NDIG-1:0] nHEX_IN;
    logic [4*NDIG-1:0] DOUT;
    logic [NDIG-1:0]   BLANK;
    logic [NDIG-1:0]   ERR;
    logic              VALID;
    logic              UPDATE;

    modport master (
        output nHEX_IN,
        input  DOUT,
        input  BLANK,
        input  ERR,
        input  VALID,
        input  UPDATE
    );

    modport slave (
        input  nHEX_IN,
        output DOUT,
        output BLANK,
        output ERR,
        output VALID,
        output UPDATE
    );
endinterface

// File: rtl/seg7_capture_chan.sv
// One digit channel: debounces a segment bus for STABLE_CYC cycles and then
// commits its decoded value, reporting when the committed value changes.
module seg7_capture_chan
    import seg7_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] dout,
    output logic       blank,
    output logic       err,
    output logic       stable,
    output logic       changed
);

    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

    logic [6:0]    sample_d, sample_q;
    logic [CW-1:0] cnt_d, cnt_q;
    seg7_dec_t     dec_d, dec_q;
    seg7_dec_t     dec_new;
    logic          commit;

    // The counter saturates at CNT_MAX, so commit happens exactly once per stable run.
    always_comb begin
        sample_d = sample_q;
        cnt_d    = cnt_q;
        commit   = 1'b0;
        dec_new  = seg7_to_bcd(sample_q);
        dec_d    = dec_q;
        if (seg_in != sample_q) begin
            sample_d = seg_in;
            cnt_d    = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d  = cnt_q + 1'b1;
            commit = (cnt_q == CNT_LAST);
        end
        if (commit) begin
            dec_d = dec_new;
        end
        changed = commit && (dec_new != dec_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_q <= SEG_BLANK;
            cnt_q    <= '0;
            dec_q    <= DEC_RESET;
        end else begin
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
            dec_q    <= dec_d;
        end
    end

    assign dout   = dec_q.bcd;
    assign blank  = dec_q.blank;
    assign err    = dec_q.err;
    assign stable = (cnt_q == CNT_MAX);

endmodule

// File: rtl/seg7_capture.sv
// Readback monitor for NDIG active-low seven-segment buses; recovers BCD digits
// once each bus has been stable long enough and flags blank/illegal patterns.
module seg7_capture #(
    parameter int NDIG       = 6,
    parameter int STABLE_CYC = 4
) (
    input  logic           CLK,
    input  logic           nRST,
    seg7_capture_if.slave  bus
);

    logic [NDIG-1:0]   stable;
    logic [NDIG-1:0]   changed;
    logic [4*NDIG-1:0] dout_w;
    logic [NDIG-1:0]   blank_w;
    logic [NDIG-1:0]   err_w;
    logic              update_d, update_q;

    genvar i;
    generate
        for (i = 0; i < NDIG; i++) begin : g_chan
            seg7_capture_chan #(
                .STABLE_CYC (STABLE_CYC)
            ) u_chan (
                .clk     (CLK),
                .rst_n   (nRST),
                .seg_in  (bus.nHEX_IN[7*i +: 7]),
                .dout    (dout_w[4*i +: 4]),
                .blank   (blank_w[i]),
                .err     (err_w[i]),
                .stable  (stable[i]),
                .changed (changed[i])
            );
        end
    endgenerate

    // Simultaneous commits on several digits collapse into one pulse.
    always_comb begin
        update_d = |changed;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            update_q <= 1'b0;
        end else begin
            update_q <= update_d;
        end
    end

    assign bus.DOUT   = dout_w;
    assign bus.BLANK  = blank_w;
    assign bus.ERR    = err_w;
    assign bus.VALID  = &stable;
    assign bus.UPDATE = update_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: UPDATE payloads are checked by a scoreboard
// monitor, level outputs are checked inline against hand-computed values.
module tb_seg7_capture;

    localparam int NDIG       = 6;
    localparam int STABLE_CYC = 4;

    // Digits 5..0 showing 12:34:56 (gfedcba, 0 = lit)
    localparam logic [41:0] HEX_BLANK  = {6{7'h7F}};
    localparam logic [41:0] HEX_123456 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [35:0] exp_q[$];
    logic [41:0] vec;

    seg7_capture_if #(.NDIG(NDIG)) bus_if ();

    seg7_capture #(
        .NDIG       (NDIG),
        .STABLE_CYC (STABLE_CYC)
    ) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [41:0] hex, input int cycles);
        bus_if.nHEX_IN = hex;
        tick(cycles);
    endtask

    task automatic expectUpdate(input logic [23:0] dout, input logic [5:0] blank, input logic [5:0] err);
        exp_q.push_back({dout, blank, err});
    endtask

    // Every UPDATE pulse must match the next queued committed value.
    always @(negedge clk) begin
        if (bus_if.UPDATE !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL update_unexpected: got UPDATE=%b with payload %h, expected no pulse",
                         bus_if.UPDATE, {bus_if.DOUT, bus_if.BLANK, bus_if.ERR});
            end else begin
                checkOutput("update_payload", {bus_if.DOUT, bus_if.BLANK, bus_if.ERR}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus_if.nHEX_IN = HEX_BLANK;
        rst_n = 1'b0;
        tick(2);
        checkOutput("rst_dout",   36'(bus_if.DOUT),   36'hFFFFFF);
        checkOutput("rst_blank",  36'(bus_if.BLANK),  36'h3F);
        checkOutput("rst_err",    36'(bus_if.ERR),    36'h00);
        checkOutput("rst_valid",  36'(bus_if.VALID),  36'h0);
        checkOutput("rst_update", 36'(bus_if.UPDATE), 36'h0);

        // All blank after release: identical recommit, VALID from edge 4
        rst_n = 1'b1;
        tick(3);
        checkOutput("blank_valid_edge3", 36'(bus_if.VALID), 36'h0);
        tick(1);
        checkOutput("blank_valid_edge4", 36'(bus_if.VALID), 36'h1);
        checkOutput("blank_blank",       36'(bus_if.BLANK), 36'h3F);
        checkOutput("blank_dout",        36'(bus_if.DOUT),  36'hFFFFFF);
        tick(6);

        // 12:34:56
        expectUpdate(24'h123456, 6'h00, 6'h00);
        applyStimulus(HEX_123456, 4);
        checkOutput("time_valid_early", 36'(bus_if.VALID), 36'h0);
        checkOutput("time_dout_early",  36'(bus_if.DOUT),  36'hFFFFFF);
        tick(1);
        checkOutput("time_valid", 36'(bus_if.VALID), 36'h1);
        checkOutput("time_dout",  36'(bus_if.DOUT),  36'h123456);
        checkOutput("time_blank", 36'(bus_if.BLANK), 36'h00);
        tick(2);

        // One-cycle glitch on digit 0
        vec = HEX_123456;
        vec[6:0] = 7'h03;
        applyStimulus(vec, 1);
        checkOutput("glitch_valid_g", 36'(bus_if.VALID), 36'h0);
        applyStimulus(HEX_123456, 0);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checkOutput("glitch_valid_low", 36'(bus_if.VALID), 36'h0);
            checkOutput("glitch_dout_hold", 36'(bus_if.DOUT),  36'h123456);
        end
        tick(1);
        checkOutput("glitch_valid_back", 36'(bus_if.VALID), 36'h1);
        checkOutput("glitch_dout_final", 36'(bus_if.DOUT),  36'h123456);
        tick(2);

        // Illegal pattern on digit 2
        vec = HEX_123456;
        vec[20:14] = 7'h3F;
        expectUpdate(24'h123F56, 6'h00, 6'h04);
        applyStimulus(vec, 8);
        checkOutput("illegal_err",   36'(bus_if.ERR),   36'h04);
        checkOutput("illegal_dout",  36'(bus_if.DOUT),  36'h123F56);
        checkOutput("illegal_blank", 36'(bus_if.BLANK), 36'h00);
        expectUpdate(24'h123456, 6'h00, 6'h00);
        applyStimulus(HEX_123456, 5);
        checkOutput("illegal_restore_dout", 36'(bus_if.DOUT), 36'h123456);
        checkOutput("illegal_restore_err",  36'(bus_if.ERR),  36'h00);

        // Digit 1 toggling 40/79 every 3 cycles never commits
        for (int k = 0; k < 8; k++) begin
            vec = HEX_123456;
            vec[13:7] = (k % 2 == 0) ? 7'h40 : 7'h79;
            applyStimulus(vec, 3);
            checkOutput("toggle_valid",   36'(bus_if.VALID),     36'h0);
            checkOutput("toggle_dout_d1", 36'(bus_if.DOUT[7:4]), 36'h5);
        end
        applyStimulus(HEX_123456, 5);
        checkOutput("toggle_recover_valid", 36'(bus_if.VALID), 36'h1);
        checkOutput("toggle_recover_dout",  36'(bus_if.DOUT),  36'h123456);

        // Reset at count 2 of a pending commit of 8 on digit 0
        vec = HEX_123456;
        vec[6:0] = 7'h00;
        applyStimulus(vec, 3);
        rst_n = 1'b0;
        tick(1);
        checkOutput("midrst_dout",  36'(bus_if.DOUT),  36'hFFFFFF);
        checkOutput("midrst_blank", 36'(bus_if.BLANK), 36'h3F);
        checkOutput("midrst_err",   36'(bus_if.ERR),   36'h00);
        checkOutput("midrst_valid", 36'(bus_if.VALID), 36'h0);
        rst_n = 1'b1;
        expectUpdate(24'h123458, 6'h00, 6'h00);
        tick(4);
        checkOutput("midrst_dout_early",  36'(bus_if.DOUT),  36'hFFFFFF);
        checkOutput("midrst_valid_early", 36'(bus_if.VALID), 36'h0);
        tick(1);
        checkOutput("midrst_dout_commit",  36'(bus_if.DOUT),  36'h123458);
        checkOutput("midrst_valid_commit", 36'(bus_if.VALID), 36'h1);
        tick(3);

        checkOutput("scoreboard_empty", 36'(exp_q.size()), 36'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
